// File: rtl/i2c_tchk_pkg.sv
// Shared defaults and I2C standard-mode timing limits for i2c_timing_chk.
// Limits are in clk cycles, scaled by US (clk cycles per microsecond).
package i2c_tchk_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned VCNT_W_DEF = 8;

  localparam int unsigned US = 50;

  localparam int unsigned PER_HD_STRT = 4 * US;
  localparam int unsigned PER_LO      = (47 * US) / 10;
  localparam int unsigned PER_HD_DATA = 0;
  localparam int unsigned PER_SU_DATA = US / 4;
  localparam int unsigned PER_HI      = 4 * US;
  localparam int unsigned PER_SU_RSRT = (47 * US) / 10;
  localparam int unsigned PER_SU_STOP = 4 * US;
  localparam int unsigned PER_TBUF    = (47 * US) / 10;

  typedef enum logic [2:0] {
    R_HD_STRT,
    R_LO,
    R_HD_DATA,
    R_SU_DATA,
    R_HI,
    R_SU_RSRT,
    R_SU_STOP,
    R_TBUF
  } tchk_rule_e;

  function automatic int unsigned rule_lim(tchk_rule_e r);
    unique case (r)
      R_HD_STRT: return PER_HD_STRT;
      R_LO:      return PER_LO;
      R_HD_DATA: return PER_HD_DATA;
      R_SU_DATA: return PER_SU_DATA;
      R_HI:      return PER_HI;
      R_SU_RSRT: return PER_SU_RSRT;
      R_SU_STOP: return PER_SU_STOP;
      R_TBUF:    return PER_TBUF;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_tchk_edge.sv
// Registered edge detector: rising edge, or any edge when any_i is set.
// The sample register tracks the input during reset; events are masked.
module i2c_tchk_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  input  logic any_i,
  output logic evt_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    sig_q <= sig_i;
  end

  always_comb begin
    evt_o = ~rst & ((sig_i & ~sig_q) | (any_i & ~sig_i & sig_q));
  end

endmodule

// File: rtl/i2c_timing_chk.sv
// I2C timing checker: flags s1-event to s2-event intervals shorter than lim.
// Define I2C_TCHK_DISPLAY_EN to print each violation in simulation.
module i2c_timing_chk
  import i2c_tchk_pkg::*;
#(
  parameter bit          E1_ANY  = 1'b0,
  parameter bit          E2_ANY  = 1'b0,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned VIO_LEN = 2,
  parameter int unsigned VCNT_W  = VCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s1,
  input  logic              s2,
  input  logic [CNT_W-1:0]  lim,
  output logic              vio,
  output logic [VCNT_W-1:0] vio_cnt,
  output logic [CNT_W-1:0]  last_dt
);

  localparam int unsigned TW = $clog2(VIO_LEN + 1);

  logic e1, e2, chk, viol;
  logic armed_q, armed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  dt_q, dt_d;
  logic [VCNT_W-1:0] vc_q, vc_d;
  logic [TW-1:0]     tmr_q, tmr_d;

  i2c_tchk_edge u_e1 (
    .clk   (clk),
    .rst   (rst),
    .sig_i (s1),
    .any_i (E1_ANY),
    .evt_o (e1)
  );

  i2c_tchk_edge u_e2 (
    .clk   (clk),
    .rst   (rst),
    .sig_i (s2),
    .any_i (E2_ANY),
    .evt_o (e2)
  );

  // cnt_q still holds the interval to the previous e1 when e1 and e2 coincide
  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q;
    dt_d    = dt_q;
    vc_d    = vc_q;
    tmr_d   = tmr_q;
    chk     = e2 & armed_q;
    viol    = chk & (cnt_q < lim);
    if (e1) begin
      cnt_d   = CNT_W'(1);
      armed_d = 1'b1;
    end else if (armed_q && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (chk) begin
      dt_d = cnt_q;
    end
    if (viol) begin
      tmr_d = TW'(VIO_LEN);
      if (vc_q != '1) begin
        vc_d = vc_q + VCNT_W'(1);
      end
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
      dt_q    <= '0;
      vc_q    <= '0;
      tmr_q   <= '0;
    end else begin
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      dt_q    <= dt_d;
      vc_q    <= vc_d;
      tmr_q   <= tmr_d;
    end
  end

`ifdef I2C_TCHK_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!rst && viol) begin
      $display("Timing violation %0d @%0t", cnt_q, $time);
    end
  end
`else
`endif

  assign vio     = (tmr_q != '0);
  assign vio_cnt = vc_q;
  assign last_dt = dt_q;

endmodule

// File: tb/tb_i2c_timing_chk.sv
// Directed bench for i2c_timing_chk: rise-only and any-edge instances,
// expected outputs queued with a due cycle and checked when it arrives.
module tb_i2c_timing_chk;

  logic clk = 1'b0;
  logic rst;
  logic a_s1, a_s2, b_s1, b_s2;
  logic [15:0] a_lim, b_lim;
  logic a_vio, b_vio;
  logic [7:0] a_vc, b_vc;
  logic [15:0] a_dt, b_dt;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int n = 0;
  int n3 = 0;

  typedef struct {
    int    due;
    int    inst;
    logic  v;
    int    vc;
    int    dt;
    string tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  i2c_timing_chk #(
    .E1_ANY (1'b0),
    .E2_ANY (1'b0)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .s1      (a_s1),
    .s2      (a_s2),
    .lim     (a_lim),
    .vio     (a_vio),
    .vio_cnt (a_vc),
    .last_dt (a_dt)
  );

  i2c_timing_chk #(
    .E1_ANY (1'b1),
    .E2_ANY (1'b1)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .s1      (b_s1),
    .s2      (b_s2),
    .lim     (b_lim),
    .vio     (b_vio),
    .vio_cnt (b_vc),
    .last_dt (b_dt)
  );

  task automatic push_exp(input int dly, input int inst, input logic v,
                          input int vc, input int dt, input string tag);
    exp_t e;
    e.due  = cyc + dly;
    e.inst = inst;
    e.v    = v;
    e.vc   = vc;
    e.dt   = dt;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check_due();
    exp_t e;
    logic ov;
    int   ovc, odt;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        e = sb[i];
        sb.delete(i);
        ov  = (e.inst == 0) ? a_vio : b_vio;
        ovc = (e.inst == 0) ? int'(a_vc) : int'(b_vc);
        odt = (e.inst == 0) ? int'(a_dt) : int'(b_dt);
        checks++;
        assert (ov === e.v) else begin
          failures++;
          $error("FAIL %s vio got=%0b exp=%0b", e.tag, ov, e.v);
        end
        checks++;
        assert (ovc === e.vc) else begin
          failures++;
          $error("FAIL %s vio_cnt got=%0d exp=%0d", e.tag, ovc, e.vc);
        end
        checks++;
        assert (odt === e.dt) else begin
          failures++;
          $error("FAIL %s last_dt got=%0d exp=%0d", e.tag, odt, e.dt);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_due();
  endtask

  task automatic run_a(input int k);
    a_s1 = 1'b1;
    repeat (k) step();
    a_s2 = 1'b1;
  endtask

  initial begin
    rst   = 1'b1;
    a_s1  = 1'b0;
    a_s2  = 1'b0;
    a_lim = 16'd0;
    b_s1  = 1'b1;
    b_s2  = 1'b1;
    b_lim = 16'd0;
    repeat (3) step();
    push_exp(1, 0, 1'b0, 0, 0, "rst_a");
    push_exp(1, 1, 1'b0, 0, 0, "rst_b");
    rst = 1'b0;
    step();

    // s2 rise with no s1 event; levels high at release
    a_s2  = 1'b1;
    a_lim = 16'd40;
    push_exp(1, 0, 1'b0, 0, 0, "t5_unarmed");
    push_exp(3, 0, 1'b0, 0, 0, "t5_unarmed_late");
    push_exp(2, 1, 1'b0, 0, 0, "t5_hi_rel");
    step();
    a_s2 = 1'b0;
    repeat (3) step();

    // lim = 0 never violates
    a_s1  = 1'b1;
    step();
    a_s2  = 1'b1;
    a_lim = 16'd0;
    push_exp(1, 0, 1'b0, 0, 1, "lim0");
    push_exp(2, 0, 1'b0, 0, 1, "lim0_late");
    step();
    a_s1  = 1'b0;
    a_s2  = 1'b0;
    a_lim = 16'd40;
    repeat (2) step();

    run_a(39);
    push_exp(1, 0, 1'b1, 1, 39, "t1_vio0");
    push_exp(2, 0, 1'b1, 1, 39, "t1_vio1");
    push_exp(3, 0, 1'b0, 1, 39, "t1_end");
    step();
    a_s1 = 1'b0;
    a_s2 = 1'b0;
    repeat (3) step();

    run_a(40);
    push_exp(1, 0, 1'b0, 1, 40, "t2_40");
    push_exp(2, 0, 1'b0, 1, 40, "t2_40_late");
    step();
    a_s1 = 1'b0;
    a_s2 = 1'b0;
    repeat (2) step();
    run_a(41);
    push_exp(1, 0, 1'b0, 1, 41, "t2_41");
    step();
    a_s1 = 1'b0;
    a_s2 = 1'b0;
    step();

    // coincident e1/e2 while unarmed: no check, arms
    b_s1 = 1'b0;
    b_s2 = 1'b0;
    push_exp(1, 1, 1'b0, 0, 0, "b_unarmed");
    repeat (2) step();
    b_s2 = 1'b1;
    push_exp(1, 1, 1'b0, 0, 2, "b_lim0");
    step();

    n3    = cyc;
    b_s1  = 1'b1;
    b_lim = 16'd5;
    repeat (3) step();
    b_s2 = 1'b0;
    push_exp(1, 1, 1'b1, 1, 3, "t3_vio0");
    push_exp(2, 1, 1'b1, 1, 3, "t3_vio1");
    push_exp(3, 1, 1'b0, 1, 3, "t3_end");
    repeat (7) step();
    b_s2 = 1'b1;
    push_exp(1, 1, 1'b0, 1, 10, "t3_10");
    step();

    // s1 == s2 on one any-edge signal
    b_s1  = 1'b0;
    b_s2  = 1'b0;
    b_lim = 16'd3;
    push_exp(1, 1, 1'b0, 1, cyc - n3, "t4_prev");
    repeat (2) step();
    b_s1 = 1'b1;
    b_s2 = 1'b1;
    push_exp(1, 1, 1'b1, 2, 2, "t4_vio0");
    push_exp(2, 1, 1'b1, 2, 2, "t4_vio1");
    push_exp(3, 1, 1'b0, 2, 2, "t4_end");
    repeat (4) step();
    b_s1 = 1'b0;
    b_s2 = 1'b0;
    push_exp(1, 1, 1'b0, 2, 4, "t4_4");
    repeat (2) step();

    // back-to-back violations, then reset during the pulse
    b_s1  = 1'b1;
    b_lim = 16'd40;
    repeat (5) step();
    b_s2 = 1'b1;
    push_exp(1, 1, 1'b1, 3, 5, "t6_v1");
    step();
    b_s2 = 1'b0;
    push_exp(1, 1, 1'b1, 4, 6, "t6_v2");
    step();
    rst = 1'b1;
    push_exp(1, 1, 1'b0, 0, 0, "t6_rst_b");
    push_exp(1, 0, 1'b0, 0, 0, "t6_rst_a");
    step();
    rst = 1'b0;
    repeat (2) step();

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
